fetch_unit: RTL

Instruction fetch stage that drives the program counter into `InstructionMemory` and registers the returned word into the IF/ID pipeline register. It sits directly upstream of `InstructionMemory`, supplying its 16-bit byte address, and directly upstream of decode, which consumes `if_*`. The stage handles sequential fetch (PC += 2), branch/jump redirects with wrong-path flush, pipeline stalls and a terminal halt.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/InstructionMemory.sv | 13 +
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC step, reset PC
// and the fetch-stage FSM state type.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP          = 16'd2;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/InstructionMemory.sv
// Combinational instruction ROM with fixed pseudo-random contents.
// Ports: addr (byte address in), instr (word out).
module InstructionMemory
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] instr
);

    // Contents: byte-swapped address XOR a constant pattern.
    assign instr = {addr[7:0], addr[15:8]} ^ 16'h5A3C;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush and hold controls.
// Ports: clk, rst, load, flush, d_pc, d_instr -> valid, pc, instr, pc_plus2.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_plus2
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            pc       <= '0;
            instr    <= '0;
            pc_plus2 <= '0;
        end else if (flush) begin
            // Only the valid bit matters on a flush; payload is left as is.
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= d_pc;
            instr    <= d_instr;
            pc_plus2 <= d_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALTED FSM, redirect/stall/halt
// handling. Ports: clk, rst, stall, redirect_*, halt_req, imem_*,
// if_* (IF/ID bundle), halted, fetch_count.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc_plus2,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              load, flush;

    // Mutually exclusive actions, encoding the per-cycle priority.
    logic is_halted, do_halt, do_redir, do_stall, do_run;

    assign is_halted = (state_q == HALTED);
    assign do_halt   = !is_halted && halt_req;
    assign do_redir  = !is_halted && !halt_req && redirect_valid;
    assign do_stall  = !is_halted && !halt_req && !redirect_valid && stall;
    assign do_run    = !is_halted && !halt_req && !redirect_valid && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (1'b1)
            is_halted: ;
            do_halt: begin
                state_d = HALTED;
                flush   = 1'b1;
            end
            do_redir: begin
                pc_d  = {redirect_pc[ADDR_W-1:1], 1'b0};
                flush = 1'b1;
            end
            do_stall: ;
            do_run: begin
                pc_d = pc_q + PC_STEP;
                load = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC & 16'hFFFE;
            fetch_count <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_count <= fetch_count + {15'd0, load};
        end
    end

    assign imem_addr = pc_q;
    assign halted    = is_halted;

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .d_pc     (pc_q),
        .d_instr  (imem_instr),
        .valid    (if_valid),
        .pc       (if_pc),
        .instr    (if_instr),
        .pc_plus2 (if_pc_plus2)
    );

endmodule
